// File: rtl/saturating_accumulator_pkg.sv
// Shared definitions for the saturating accumulator slice (package machina_pkg):
// accumulator width derivation, controller state encoding and clamp bounds.
package machina_pkg;

  // Controller states: summing terms, or holding a finished result.
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Accumulator width: the term width plus the guard headroom.
  function automatic int acc_width(input int width, input int guard);
    return width + guard;
  endfunction

  // Largest magnitude exponent that still fits a signed WIDTH-bit result.
  function automatic int eff_limit(input int width, input int limit);
    return (limit < width) ? limit : (width - 1);
  endfunction

  // Upper clamp bound 2^LIMIT - 1.
  function automatic longint sat_max(input int width, input int limit);
    return (64'sd1 <<< eff_limit(width, limit)) - 64'sd1;
  endfunction

  // Lower clamp bound -2^LIMIT.
  function automatic longint sat_min(input int width, input int limit);
    return -(64'sd1 <<< eff_limit(width, limit));
  endfunction

endpackage

// File: rtl/saturating_accumulator_if.sv
// Term and result handshakes of the saturating accumulator.
// master: the side driving terms and accepting results; slave: the accumulator.
interface saturating_accumulator_if #(
  parameter int WIDTH = 16
);

  logic signed [WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_sat;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

endinterface

// File: rtl/saturating_accumulator_clamp.sv
// accumulator_clamp: combinational signed clamp of an IN_W-bit value to
// [-2^LIMIT_BITS, 2^LIMIT_BITS-1], truncated to OUT_W bits, with a flag
// raised only when the value lay strictly outside the range.
module accumulator_clamp
  import machina_pkg::*;
#(
  parameter int IN_W       = 25,
  parameter int OUT_W      = 24,
  parameter int LIMIT_BITS = 23
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamped
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W, LIMIT_BITS));
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W, LIMIT_BITS));

  // Signed compare at full input width; values equal to a bound pass untouched.
  always_comb begin
    dout    = din[OUT_W-1:0];
    clamped = 1'b0;
    if (din > MAX_V) begin
      dout    = MAX_V[OUT_W-1:0];
      clamped = 1'b1;
    end else if (din < MIN_V) begin
      dout    = MIN_V[OUT_W-1:0];
      clamped = 1'b1;
    end else begin
      dout    = din[OUT_W-1:0];
      clamped = 1'b0;
    end
  end

endmodule

// File: rtl/saturating_accumulator.sv
// saturating_accumulator: sums signed terms in a guarded accumulator and,
// on the last term, presents the result clamped to the LIMIT-bit signed range.
// Optional feature macro: SATURATING_ACCUMULATOR_STICKY_EN -- when defined,
// out_sat also reports any guard-range clamp seen during the product.
module saturating_accumulator
  import machina_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LIMIT = WIDTH - 1,
  parameter int GUARD = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  saturating_accumulator_if.slave  bus
);

  localparam int ACC_W = acc_width(WIDTH, GUARD);

  localparam logic [0:0] ACCUM = ST_ACCUM;
  localparam logic [0:0] HOLD  = ST_HOLD;

  logic [0:0]              state_r;
  logic                    first_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [WIDTH-1:0] out_data_r;
  logic                    out_sat_r;
  logic                    out_valid_r;
  logic                    in_ready_r;

  logic signed [ACC_W:0]   term_ext_s;
  logic signed [ACC_W:0]   acc_ext_s;
  logic signed [ACC_W:0]   sum_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic                    guard_flag_s;
  logic signed [ACC_W:0]   final_in_s;
  logic signed [WIDTH-1:0] result_s;
  logic                    final_flag_s;
  logic                    sat_next_s;
  logic                    in_fire_s;
  logic                    out_fire_s;

  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;

  assign term_ext_s = {{(GUARD + 1){bus.in_data[WIDTH-1]}}, bus.in_data};
  assign acc_ext_s  = {acc_r[ACC_W-1], acc_r};

  // First term of a product loads; later terms add one bit wider than the accumulator.
  always_comb begin
    sum_s = term_ext_s;
    if (first_r) begin
      sum_s = term_ext_s;
    end else begin
      sum_s = acc_ext_s + term_ext_s;
    end
  end

  accumulator_clamp #(
    .IN_W       (ACC_W + 1),
    .OUT_W      (ACC_W),
    .LIMIT_BITS (ACC_W - 1)
  ) u_guard_clamp (
    .din     (sum_s),
    .dout    (acc_next_s),
    .clamped (guard_flag_s)
  );

  assign final_in_s = {acc_next_s[ACC_W-1], acc_next_s};

  accumulator_clamp #(
    .IN_W       (ACC_W + 1),
    .OUT_W      (WIDTH),
    .LIMIT_BITS (LIMIT)
  ) u_final_clamp (
    .din     (final_in_s),
    .dout    (result_s),
    .clamped (final_flag_s)
  );

`ifdef SATURATING_ACCUMULATOR_STICKY_EN
  logic sticky_r;

  // Remember any guard clamp until the result is handed off.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_r <= 1'b0;
    end else if (out_fire_s) begin
      sticky_r <= 1'b0;
    end else if (in_fire_s && guard_flag_s) begin
      sticky_r <= 1'b1;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign sat_next_s = final_flag_s | guard_flag_s | sticky_r;
`else
  logic unused_flags_s;

  assign unused_flags_s = guard_flag_s | final_flag_s;
  assign sat_next_s     = 1'b0;
`endif

  // Controller: accumulate terms, then hold the clamped result until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ACCUM;
      first_r     <= 1'b1;
      acc_r       <= '0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_fire_s) begin
            acc_r <= acc_next_s;
            if (bus.in_last) begin
              out_data_r  <= result_s;
              out_sat_r   <= sat_next_s;
              first_r     <= 1'b1;
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              first_r <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (out_fire_s) begin
            state_r     <= ACCUM;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ACCUM;
          first_r     <= 1'b1;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_saturating_accumulator.sv
// Scoreboard bench for saturating_accumulator (WIDTH=16, LIMIT=15, GUARD=8).
module tb_saturating_accumulator;

  localparam int WIDTH = 16;

`ifdef SATURATING_ACCUMULATOR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  saturating_accumulator_if #(.WIDTH(WIDTH)) bus ();

  saturating_accumulator #(
    .WIDTH (16),
    .LIMIT (15),
    .GUARD (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_res(input int d, input logic s);
    exp_q.push_back({16'(d), s});
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the beat.
  task automatic send(input int d, input logic l);
    int n;
    n = 0;
    bus.in_data  = 16'(d);
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) check("send_timeout", n, 0);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 2000) check("drain_timeout", n, 0);
  endtask

  // Monitor: every result handshake pops and checks the next expected result.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_data", int'(bus.out_data), int'($signed(mon_e[WIDTH:1])));
        check("result_sat", int'(bus.out_sat), int'(mon_e[0]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_out_sat", int'(bus.out_sat), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);

    // Plain sum with one-cycle latency
    bus.out_ready = 1'b1;
    expect_res(75, 1'b0);
    send(100, 1'b0); send(-30, 1'b0); send(5, 1'b1);
    check("latency_out_valid", int'(bus.out_valid), 1);
    check("hold_in_ready_low", int'(bus.in_ready), 0);
    wait_drain();

    // Final clamp both directions
    expect_res(32767, STICKY);
    send(20000, 1'b0); send(20000, 1'b1);
    expect_res(-32768, STICKY);
    send(-20000, 1'b0); send(-20000, 1'b1);
    wait_drain();

    // Exact bounds pass unflagged; single-term products
    expect_res(32767, 1'b0);
    send(16384, 1'b0); send(16383, 1'b1);
    expect_res(-32768, 1'b0);
    send(-32768, 1'b1);
    expect_res(-5, 1'b0);
    send(-5, 1'b1);
    wait_drain();

    // Guard clamp reached, then final clamp
    expect_res(32767, STICKY);
    for (int i = 0; i < 300; i++) send(32767, 1'b0);
    send(-32768, 1'b1);
    wait_drain();

    // Guard clamp reached, final sum back in range: only sticky flags it
    expect_res(-1, STICKY);
    for (int i = 0; i < 300; i++) send(32767, 1'b0);
    for (int i = 0; i < 255; i++) send(-32768, 1'b0);
    send(-32768, 1'b1);
    wait_drain();

    // Backpressure: result held, offered beats refused
    bus.out_ready = 1'b0;
    expect_res(30, 1'b0);
    send(10, 1'b0); send(20, 1'b1);
    bus.in_data  = 16'(999);
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_out_data", int'(bus.out_data), 30);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    check("release_out_valid", int'(bus.out_valid), 0);
    expect_res(4, 1'b0);
    send(4, 1'b1);
    wait_drain();

    // Reset mid-product discards the partial sum
    send(1, 1'b0); send(2, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_in_ready", int'(bus.in_ready), 1);
    expect_res(7, 1'b0);
    send(7, 1'b1);
    wait_drain();

    // Reset while holding discards the undelivered result
    bus.out_ready = 1'b0;
    send(9, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("holdreset_out_valid", int'(bus.out_valid), 0);
    check("holdreset_out_data", int'(bus.out_data), 0);
    check("holdreset_in_ready", int'(bus.in_ready), 1);

    // Back-to-back single-term products, one result per two cycles
    bus.out_ready = 1'b1;
    expect_res(1, 1'b0); expect_res(2, 1'b0); expect_res(3, 1'b0);
    t0 = cyc;
    send(1, 1'b1); send(2, 1'b1); send(3, 1'b1);
    check("b2b_cycles", cyc - t0, 5);
    wait_drain();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
